mem_req_responder: RTL and testbench
====================================

# mem_req_responder

Single-port memory responder: the target end of the val/rdy memreq/memresp interface that the pipelined processor drives for instruction and data accesses. It accepts one request per cycle, performs the read or write against an internal word array, and returns an in-order response after a fixed LATENCY. An internal response queue absorbs back-pressure, so the block sustains full throughput while resp_rdy is high. One instance per port: imem and dmem in the processor test harness.

## Interface
- NWORDS, 256: memory size in 32-bit words; power of two, ≥ 4.
- LATENCY, 1: cycles from request acceptance to earliest resp_val; ≥ 1.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_val  in  1  request valid.
- req_rdy  out  1  request ready.
- req_type  in  3  0 = read, 1 = write; any other value is illegal.
- req_opaque  in  8  tag, echoed in the response.
- req_addr  in  32  byte address.
- req_len  in  2  byte count; 0 means 4.
- req_data  in  32  write data, least-significant bytes used.
- resp_val  out  1  response valid.
- resp_rdy  in  1  response ready.
- resp_type  out  3  echo of req_type.
- resp_opaque  out  8  echo of req_opaque.
- resp_len  out  2  echo of req_len.
- resp_data  out  32  read data, zero-extended; 0 for writes and for errors.
- err  out  1  sticky error flag.

## Operation
- Word index = req_addr[log2(NWORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo NWORDS*4. Byte offset = req_addr[1:0]. Byte order is little-endian.
- nbytes = (req_len == 0) ? 4 : req_len.
- A request is accepted on an edge where req_val && req_rdy.
- Read: at acceptance, the block captures bytes [off, off+nbytes) of the word, shifted down to bit 0 and zero-extended.
- Write: at the acceptance edge, the block writes the low nbytes of req_data into bytes [off, off+nbytes). Other bytes are unchanged.
- Ordering: a read sees every write accepted on an earlier edge. Responses return strictly in acceptance order.
- Illegal request: req_type not in {0,1}, or off+nbytes > 4.
  - Memory is not modified.
  - The request still produces a response, with resp_data = 0.
  - err is set on the acceptance edge and stays 1 until reset.
- Structure: a LATENCY-stage delay line of response records with valid bits, feeding a response queue of depth Q = LATENCY+1. resp_* are driven from the queue head.
- Credit count C = entries in the delay line + entries in the queue. C increments on accept and decrements on dequeue (resp_val && resp_rdy); simultaneous accept and dequeue leave C unchanged.
- req_rdy = !reset && (C < Q).
- req_rdy has no combinational dependence on resp_rdy or req_val. resp_val depends only on state.
- Memory contents are not reset. Reads of never-written words return X.

## Timing
- Reset: all outputs are 0 during and after the reset cycle, except req_rdy, which is 1 in the first cycle after reset deasserts.
- Reset clears C, the delay line, the queue and err. In-flight requests are discarded with no response. Writes already accepted remain in memory.
- Latency: a request accepted at edge t produces resp_val in cycle t+LATENCY (after edge t+LATENCY-1 … i.e. LATENCY edges later) when the queue ahead of it is empty and resp_rdy stays high.
- Throughput: with resp_rdy held at 1, one request is accepted per cycle indefinitely and C settles at LATENCY.
- Back-pressure: with resp_rdy = 0, exactly Q requests are accepted, then req_rdy drops. req_rdy rises in the cycle after the first dequeue edge.
- Full/empty boundary: when C == Q and a dequeue occurs, req_rdy stays 0 that cycle; a new request is accepted the next cycle. The queue never overflows, so no response is lost.
- The queue head is stable while resp_val && !resp_rdy.

## Test plan
- Write then read, LATENCY=1:
  - Stimulus: write addr 0x10, len 0, data 0xDEADBEEF, opaque 0x01; then read 0x10, opaque 0x02, on back-to-back cycles with resp_rdy=1.
  - Required: response type 1, data 0, opaque 0x01; next cycle response type 0, data 0xDEADBEEF, opaque 0x02; err=0.
- Subword access:
  - Stimulus: write 0x11223344 to 0x20; write byte 0xAA, len 1, at 0x22; read len 2 at 0x22; read len 0 at 0x20.
  - Required: reads return 0x000011AA and 0x11AA3344.
- Back-pressure, LATENCY=2:
  - Stimulus: hold resp_rdy=0, offer 5 reads.
  - Required: exactly 3 accepted, then req_rdy=0. After raising resp_rdy, responses drain in order with matching opaques, and req_rdy=1 one cycle after the first dequeue.
- Wrap and full throughput, NWORDS=256:
  - Stimulus: write 0x5 to addr 0x400, read addr 0x0; then stream 20 reads with resp_rdy=1.
  - Required: read returns 0x5; one response per cycle, no bubbles after the first LATENCY cycles.
- Illegal request and reset:
  - Stimulus: read len 2 at 0x3; then reset with 2 requests in flight.
  - Required: response data 0, err=1, memory unchanged; after reset err=0, resp_val=0, no stale responses, req_rdy=1 the cycle after reset drops.

Source files
------------

// File: rtl/mem_req_responder.sv
// +--------------------------------------------------------------------------+
// | mem_req_responder: val/rdy memory target, byte-lane access, in-order resp |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_req_responder #(
  parameter int NWORDS  = 256,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [2:0]  req_type,
  input  logic [7:0]  req_opaque,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_len,
  input  logic [31:0] req_data,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [2:0]  resp_type,
  output logic [7:0]  resp_opaque,
  output logic [1:0]  resp_len,
  output logic [31:0] resp_data,
  output logic        err
);

  localparam int c_aw    = $clog2(NWORDS);
  localparam int c_depth = LATENCY + 1;
  localparam int c_pw    = $clog2(c_depth);
  localparam int c_cw    = $clog2(c_depth + 1);

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  len;
    logic [31:0] data;
  } rec_t;

  logic [31:0]      r_mem [NWORDS];
  rec_t             r_q [c_depth];
  logic [c_pw-1:0]  r_head;
  logic [c_pw-1:0]  r_tail;
  logic [c_cw-1:0]  r_qcnt;
  logic [c_cw-1:0]  r_cred;
  logic             r_err;

  logic             w_accept;
  logic             w_deq;
  logic             w_enq;
  logic             w_resp_val;
  logic             w_illegal;
  logic             w_is_write;
  logic [c_aw-1:0]  w_idx;
  logic [1:0]       w_off;
  logic [2:0]       w_nbytes;
  logic [2:0]       w_end;
  logic [3:0]       w_be;
  logic [31:0]      w_word;
  logic [31:0]      w_shift;
  logic [31:0]      w_rdata;
  logic [31:0]      w_wdata;
  rec_t             w_new;
  rec_t             w_head;
  logic             w_unused_addr;

  logic [LATENCY-1:0] w_stage_v;
  rec_t [LATENCY-1:0] w_stage_rec;

  function automatic logic [c_pw-1:0] f_inc(input logic [c_pw-1:0] p);
    return (p == c_pw'(c_depth - 1)) ? '0 : p + c_pw'(1);
  endfunction

  // ---------------------------------------------------------------- decode
  assign w_idx         = req_addr[c_aw+1:2];
  assign w_off         = req_addr[1:0];
  assign w_unused_addr = ^req_addr[31:c_aw+2];
  assign w_nbytes      = (req_len == 2'd0) ? 3'd4 : {1'b0, req_len};
  assign w_end         = {1'b0, w_off} + w_nbytes;
  assign w_illegal     = (req_type > 3'd1) || (w_end > 3'd4);
  assign w_is_write    = (req_type == 3'd1) && !w_illegal;

  assign req_rdy  = !reset && (r_cred < c_cw'(c_depth));
  assign w_accept = req_val && req_rdy;

  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_off, 3'b000};
  assign w_wdata = req_data << {w_off, 3'b000};

  always_comb begin
    w_rdata = '0;
    w_be    = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < w_nbytes) w_rdata[8*k +: 8] = w_shift[8*k +: 8];
      w_be[k] = (3'(k) >= {1'b0, w_off}) && (3'(k) < w_end);
    end
  end

  // Memory is deliberately left out of reset so accepted writes survive it.
  always_ff @(posedge clk) begin
    if (w_accept && w_is_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_new        = '0;
    w_new.typ    = req_type;
    w_new.opaque = req_opaque;
    w_new.len    = req_len;
    w_new.data   = ((req_type == 3'd0) && !w_illegal) ? w_rdata : 32'd0;
  end

  // ---------------------------------------------------------- delay line
  // Stage 0 is the request itself; the final stage writes into the queue, so
  // the queue write is the LATENCY-th register in the response path.
  assign w_stage_v[0]   = w_accept;
  assign w_stage_rec[0] = w_new;

  for (genvar i = 1; i < LATENCY; i++) begin : g_dl
    logic r_v;
    rec_t r_rec;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_v   <= 1'b0;
        r_rec <= '0;
      end else begin
        r_v   <= w_stage_v[i-1];
        r_rec <= w_stage_rec[i-1];
      end
    end
    assign w_stage_v[i]   = r_v;
    assign w_stage_rec[i] = r_rec;
  end

  assign w_enq = w_stage_v[LATENCY-1];

  // -------------------------------------------------------- response queue
  always_ff @(posedge clk) begin
    if (w_enq) r_q[r_tail] <= w_stage_rec[LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_qcnt <= '0;
      r_cred <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_enq) r_tail <= f_inc(r_tail);
      if (w_deq) r_head <= f_inc(r_head);
      case ({w_enq, w_deq})
        2'b10:   r_qcnt <= r_qcnt + c_cw'(1);
        2'b01:   r_qcnt <= r_qcnt - c_cw'(1);
        default: r_qcnt <= r_qcnt;
      endcase
      case ({w_accept, w_deq})
        2'b10:   r_cred <= r_cred + c_cw'(1);
        2'b01:   r_cred <= r_cred - c_cw'(1);
        default: r_cred <= r_cred;
      endcase
      if (w_accept && w_illegal) r_err <= 1'b1;
    end
  end

  // Outputs are forced low while reset is asserted, before the state clears.
  assign w_head      = r_q[r_head];
  assign w_resp_val  = !reset && (r_qcnt != '0);
  assign w_deq       = w_resp_val && resp_rdy;
  assign resp_val    = w_resp_val;
  assign resp_type   = w_resp_val ? w_head.typ    : 3'd0;
  assign resp_opaque = w_resp_val ? w_head.opaque : 8'd0;
  assign resp_len    = w_resp_val ? w_head.len    : 2'd0;
  assign resp_data   = w_resp_val ? w_head.data   : 32'd0;
  assign err         = r_err && !reset;

endmodule

`default_nettype wire

// File: tb/tb_mem_req_responder.sv
// +--------------------------------------------------------------------------+
// | tb_mem_req_responder: directed bench, LATENCY=1 and LATENCY=2 instances   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_req_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_type;
  logic [7:0]  req_opaque;
  logic [31:0] req_addr;
  logic [1:0]  req_len;
  logic [31:0] req_data;

  logic        req_val1, req_rdy1, resp_val1, resp_rdy1, err1;
  logic [2:0]  resp_type1;
  logic [7:0]  resp_opaque1;
  logic [1:0]  resp_len1;
  logic [31:0] resp_data1;

  logic        req_val2, req_rdy2, resp_val2, resp_rdy2, err2;
  logic [2:0]  resp_type2;
  logic [7:0]  resp_opaque2;
  logic [1:0]  resp_len2;
  logic [31:0] resp_data2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_req_responder #(.NWORDS(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_val(req_val1), .req_rdy(req_rdy1), .req_type(req_type),
    .req_opaque(req_opaque), .req_addr(req_addr), .req_len(req_len),
    .req_data(req_data), .resp_val(resp_val1), .resp_rdy(resp_rdy1),
    .resp_type(resp_type1), .resp_opaque(resp_opaque1), .resp_len(resp_len1),
    .resp_data(resp_data1), .err(err1)
  );

  mem_req_responder #(.NWORDS(256), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .req_val(req_val2), .req_rdy(req_rdy2), .req_type(req_type),
    .req_opaque(req_opaque), .req_addr(req_addr), .req_len(req_len),
    .req_data(req_data), .resp_val(resp_val2), .resp_rdy(resp_rdy2),
    .resp_type(resp_type2), .resp_opaque(resp_opaque2), .resp_len(resp_len2),
    .resp_data(resp_data2), .err(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                         input logic [1:0] l, input logic [31:0] d);
    req_type   = t;
    req_opaque = op;
    req_addr   = a;
    req_len    = l;
    req_data   = d;
  endtask

  task automatic chk_resp1(input string tag, input logic [2:0] t, input logic [7:0] op,
                           input logic [31:0] d);
    chk({tag, "_val"},  {31'd0, resp_val1}, 32'd1);
    chk({tag, "_type"}, {29'd0, resp_type1}, {29'd0, t});
    chk({tag, "_op"},   {24'd0, resp_opaque1}, {24'd0, op});
    chk({tag, "_data"}, resp_data1, d);
  endtask

  initial begin
    reset = 1'b1;
    req_val1 = 1'b0; req_val2 = 1'b0;
    resp_rdy1 = 1'b0; resp_rdy2 = 1'b0;
    set_req(3'd0, 8'd0, 32'd0, 2'd0, 32'd0);

    // ---- reset state
    tick();
    tick();
    chk("rst_rdy1", {31'd0, req_rdy1}, 32'd0);
    chk("rst_val1", {31'd0, resp_val1}, 32'd0);
    chk("rst_err1", {31'd0, err1}, 32'd0);
    chk("rst_val2", {31'd0, resp_val2}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_rdy1", {31'd0, req_rdy1}, 32'd1);
    chk("post_rst_rdy2", {31'd0, req_rdy2}, 32'd1);

    // ---- write then read, LATENCY=1
    resp_rdy1 = 1'b1;
    req_val1  = 1'b1;
    set_req(3'd1, 8'h01, 32'h10, 2'd0, 32'hDEADBEEF);
    tick();
    chk_resp1("wr", 3'd1, 8'h01, 32'd0);
    set_req(3'd0, 8'h02, 32'h10, 2'd0, 32'd0);
    tick();
    chk_resp1("rd", 3'd0, 8'h02, 32'hDEADBEEF);
    chk("rd_err", {31'd0, err1}, 32'd0);

    // ---- subword access
    set_req(3'd1, 8'h03, 32'h20, 2'd0, 32'h11223344);
    tick();
    set_req(3'd1, 8'h04, 32'h22, 2'd1, 32'h000000AA);
    tick();
    set_req(3'd0, 8'h05, 32'h22, 2'd2, 32'd0);
    tick();
    chk_resp1("sub_h", 3'd0, 8'h05, 32'h000011AA);
    chk("sub_h_len", {30'd0, resp_len1}, 32'd2);
    set_req(3'd0, 8'h06, 32'h20, 2'd0, 32'd0);
    tick();
    chk_resp1("sub_w", 3'd0, 8'h06, 32'h11AA3344);

    // ---- address wrap
    set_req(3'd1, 8'h07, 32'h400, 2'd0, 32'h5);
    tick();
    set_req(3'd0, 8'h08, 32'h0, 2'd0, 32'd0);
    tick();
    chk_resp1("wrap", 3'd0, 8'h08, 32'h5);

    // ---- full throughput: one response per cycle
    for (int k = 0; k < 20; k++) begin
      set_req(3'd0, 8'(8'h40 + k), 32'h0, 2'd0, 32'd0);
      tick();
      chk($sformatf("tp%0d_rdy", k), {31'd0, req_rdy1}, 32'd1);
      chk_resp1($sformatf("tp%0d", k), 3'd0, 8'(8'h40 + k), 32'h5);
    end

    // ---- illegal requests
    set_req(3'd0, 8'h09, 32'h3, 2'd2, 32'd0);
    tick();
    chk_resp1("ill_rd", 3'd0, 8'h09, 32'd0);
    chk("ill_err", {31'd0, err1}, 32'd1);
    set_req(3'd1, 8'h0A, 32'h23, 2'd2, 32'h0000FFFF);
    tick();
    chk_resp1("ill_wr", 3'd1, 8'h0A, 32'd0);
    set_req(3'd2, 8'h0B, 32'h20, 2'd0, 32'hFFFFFFFF);
    tick();
    chk_resp1("ill_type", 3'd2, 8'h0B, 32'd0);
    set_req(3'd0, 8'h0C, 32'h20, 2'd0, 32'd0);
    tick();
    chk_resp1("ill_mem", 3'd0, 8'h0C, 32'h11AA3344);
    chk("ill_err_sticky", {31'd0, err1}, 32'd1);
    req_val1 = 1'b0;
    tick();
    chk("idle_val1", {31'd0, resp_val1}, 32'd0);

    // ---- LATENCY=2: prime memory, then back-pressure
    resp_rdy2 = 1'b1;
    req_val2  = 1'b1;
    set_req(3'd1, 8'h0D, 32'h40, 2'd0, 32'hCAFEF00D);
    tick();
    req_val2 = 1'b0;
    chk("l2_lat_val", {31'd0, resp_val2}, 32'd0);
    tick();
    chk("l2_wr_val", {31'd0, resp_val2}, 32'd1);
    chk("l2_wr_op", {24'd0, resp_opaque2}, 32'h0D);
    tick();
    chk("l2_idle", {31'd0, resp_val2}, 32'd0);

    resp_rdy2 = 1'b0;
    req_val2  = 1'b1;
    set_req(3'd0, 8'h10, 32'h40, 2'd0, 32'd0);
    tick();
    chk("bp0_rdy", {31'd0, req_rdy2}, 32'd1);
    chk("bp0_val", {31'd0, resp_val2}, 32'd0);
    set_req(3'd0, 8'h11, 32'h40, 2'd0, 32'd0);
    tick();
    chk("bp1_rdy", {31'd0, req_rdy2}, 32'd1);
    chk("bp1_val", {31'd0, resp_val2}, 32'd1);
    chk("bp1_op", {24'd0, resp_opaque2}, 32'h10);
    set_req(3'd0, 8'h12, 32'h40, 2'd0, 32'd0);
    tick();
    chk("bp2_rdy", {31'd0, req_rdy2}, 32'd0);
    set_req(3'd0, 8'h13, 32'h40, 2'd0, 32'd0);
    tick();
    chk("bp3_rdy", {31'd0, req_rdy2}, 32'd0);
    tick();
    chk("bp4_rdy", {31'd0, req_rdy2}, 32'd0);
    chk("bp4_op", {24'd0, resp_opaque2}, 32'h10);
    chk("bp4_data", resp_data2, 32'hCAFEF00D);
    resp_rdy2 = 1'b1;
    #1;
    chk("bp_full_rdy", {31'd0, req_rdy2}, 32'd0);
    tick();
    chk("dr0_rdy", {31'd0, req_rdy2}, 32'd1);
    chk("dr0_op", {24'd0, resp_opaque2}, 32'h11);
    tick();
    req_val2 = 1'b0;
    chk("dr1_op", {24'd0, resp_opaque2}, 32'h12);
    tick();
    chk("dr2_op", {24'd0, resp_opaque2}, 32'h13);
    chk("dr2_data", resp_data2, 32'hCAFEF00D);
    tick();
    chk("dr3_val", {31'd0, resp_val2}, 32'd0);
    chk("l2_err", {31'd0, err2}, 32'd0);

    // ---- reset with two requests in flight (LATENCY=1)
    resp_rdy1 = 1'b0;
    req_val1  = 1'b1;
    set_req(3'd1, 8'hA0, 32'h30, 2'd0, 32'h12345678);
    tick();
    set_req(3'd0, 8'hA1, 32'h30, 2'd0, 32'd0);
    tick();
    chk("fl_rdy", {31'd0, req_rdy1}, 32'd0);
    req_val1 = 1'b0;
    reset    = 1'b1;
    #1;
    chk("inrst_val", {31'd0, resp_val1}, 32'd0);
    chk("inrst_err", {31'd0, err1}, 32'd0);
    chk("inrst_rdy", {31'd0, req_rdy1}, 32'd0);
    tick();
    chk("inrst2_val", {31'd0, resp_val1}, 32'd0);
    reset = 1'b0;
    #1;
    chk("afrst_rdy", {31'd0, req_rdy1}, 32'd1);
    chk("afrst_val", {31'd0, resp_val1}, 32'd0);
    chk("afrst_err", {31'd0, err1}, 32'd0);
    resp_rdy1 = 1'b1;
    tick();
    chk("stale_val", {31'd0, resp_val1}, 32'd0);
    req_val1 = 1'b1;
    set_req(3'd0, 8'hA2, 32'h30, 2'd0, 32'd0);
    tick();
    chk_resp1("kept_wr", 3'd0, 8'hA2, 32'h12345678);
    req_val1 = 1'b0;
    tick();
    chk("end_val", {31'd0, resp_val1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
